fft_scan_ctrl: RTL and testbench

FFT_SCAN_CTRL -- requirements
Module: fft_scan_ctrl

---
 rtl/fft_scan_ctrl_pkg.sv | 31 +++
 rtl/fft_peak_acc.sv | 70 +++++++
 rtl/fft_scan_ctrl.sv | 170 +++++++++++++++++
 tb/tb_fft_scan_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_scan_ctrl_pkg.sv
// Shared types, default widths and width helpers for the FFT scan controller.
package fft_scan_ctrl_pkg;

    localparam int unsigned DEF_ADDR_W = 10;
    localparam int unsigned DEF_PWR_W  = 16;
    localparam int unsigned DEF_RD_LAT = 2;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        WAIT_DONE = 3'd2,
        SCAN      = 3'd3,
        DRAIN     = 3'd4,
        REPORT    = 3'd5
    } state_e;

    // A sum of at most 2^addr_w words of pwr_w bits fits in pwr_w + addr_w bits.
    function automatic int unsigned band_sum_w(input int unsigned pwr_w, input int unsigned addr_w);
        return pwr_w + addr_w;
    endfunction

    // Counter width able to hold the longest of the timed states.
    function automatic int unsigned cnt_w(input int unsigned a, input int unsigned b, input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/fft_peak_acc.sv
// Pairs returning power samples with their bin address and tracks band sum and peak.
module fft_peak_acc
    import fft_scan_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned PWR_W  = DEF_PWR_W,
    parameter int unsigned RD_LAT = DEF_RD_LAT,
    parameter int unsigned SUM_W  = band_sum_w(DEF_PWR_W, DEF_ADDR_W)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_clear,
    input  logic              i_vld,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [PWR_W-1:0]  i_power,
    output logic [ADDR_W-1:0] o_peak_bin,
    output logic [PWR_W-1:0]  o_peak_power,
    output logic [SUM_W-1:0]  o_band_sum
);

    logic [RD_LAT-1:0] r_vld_dly;
    logic [ADDR_W-1:0] r_addr_dly [RD_LAT];
    logic              r_have;
    logic [ADDR_W-1:0] r_peak_bin;
    logic [PWR_W-1:0]  r_peak_power;
    logic [SUM_W-1:0]  r_band_sum;

    logic              w_smp_vld;
    logic [ADDR_W-1:0] w_smp_bin;

    assign w_smp_vld = r_vld_dly[RD_LAT-1];
    assign w_smp_bin = r_addr_dly[RD_LAT-1];

    // Valid/address delay line matching the read latency of the FFT memory.
    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_vld_dly <= '0;
            for (int i = 0; i < int'(RD_LAT); i++) r_addr_dly[i] <= '0;
        end else begin
            r_vld_dly[0]  <= i_vld;
            r_addr_dly[0] <= i_addr;
            for (int i = 1; i < int'(RD_LAT); i++) begin
                r_vld_dly[i]  <= r_vld_dly[i-1];
                r_addr_dly[i] <= r_addr_dly[i-1];
            end
        end
    end

    // Band sum and strict-greater peak; the first sample of a sweep always loads.
    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_have       <= 1'b0;
            r_peak_bin   <= '0;
            r_peak_power <= '0;
            r_band_sum   <= '0;
        end else if (w_smp_vld) begin
            r_have     <= 1'b1;
            r_band_sum <= r_band_sum + SUM_W'(i_power);
            if (!r_have || (i_power > r_peak_power)) begin
                r_peak_bin   <= w_smp_bin;
                r_peak_power <= i_power;
            end
        end
    end

    assign o_peak_bin   = r_peak_bin;
    assign o_peak_power = r_peak_power;
    assign o_band_sum   = r_band_sum;

endmodule

// File: rtl/fft_scan_ctrl.sv
// Sweep controller: starts an FFT, waits for done, scans a bin window and reports the peak.
module fft_scan_ctrl
    import fft_scan_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W    = DEF_ADDR_W,
    parameter int unsigned PWR_W     = DEF_PWR_W,
    parameter int unsigned RD_LAT    = DEF_RD_LAT,
    parameter int unsigned START_CYC = 4,
    parameter int unsigned TMO_CYC   = 32'd1 << 20
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   enable,
    input  logic                                   auto_mode,
    input  logic                                   trig,
    input  logic [ADDR_W-1:0]                      bin_lo,
    input  logic [ADDR_W-1:0]                      bin_hi,
    input  logic [PWR_W-1:0]                       threshold,
    output logic                                   fft_start,
    input  logic                                   fft_done,
    output logic [ADDR_W-1:0]                      fft_addr,
    input  logic [PWR_W-1:0]                       fft_power,
    input  logic [5:0]                             fft_exp,
    output logic                                   busy,
    output logic                                   result_valid,
    output logic [ADDR_W-1:0]                      peak_bin,
    output logic [PWR_W-1:0]                       peak_power,
    output logic [5:0]                             peak_exp,
    output logic [band_sum_w(PWR_W, ADDR_W)-1:0]   band_sum,
    output logic                                   above_thresh,
    output logic                                   timeout_err
);

    localparam int unsigned SUM_W = band_sum_w(PWR_W, ADDR_W);
    localparam int unsigned CNT_W = cnt_w(START_CYC, RD_LAT, TMO_CYC);

    state_e            r_state;
    state_e            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_done_q;
    logic              r_done_qq;
    logic [ADDR_W-1:0] r_lo;
    logic [ADDR_W-1:0] r_hi;
    logic [PWR_W-1:0]  r_thr;
    logic [ADDR_W-1:0] r_addr;
    logic              r_fft_start;
    logic              r_busy;

    logic              r_result_valid;
    logic [ADDR_W-1:0] r_peak_bin;
    logic [PWR_W-1:0]  r_peak_power;
    logic [5:0]        r_peak_exp;
    logic [SUM_W-1:0]  r_band_sum;
    logic              r_above;
    logic              r_tmo_err;

    logic              w_done_rise;
    logic              w_start_entry;
    logic [ADDR_W-1:0] w_acc_bin;
    logic [PWR_W-1:0]  w_acc_power;
    logic [SUM_W-1:0]  w_acc_sum;

    assign w_done_rise   = r_done_q & ~r_done_qq;
    assign w_start_entry = (w_state_nxt == START) && (r_state != START);

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:      if (enable && (trig || auto_mode)) w_state_nxt = START;
            START:     if (r_cnt == CNT_W'(START_CYC - 1)) w_state_nxt = WAIT_DONE;
            WAIT_DONE: begin
                if (w_done_rise)                       w_state_nxt = SCAN;
                else if (r_cnt == CNT_W'(TMO_CYC - 1)) w_state_nxt = IDLE;
            end
            SCAN:      if (r_addr == r_hi) w_state_nxt = DRAIN;
            DRAIN:     if (r_cnt == CNT_W'(RD_LAT - 1)) w_state_nxt = REPORT;
            REPORT:    w_state_nxt = (enable && auto_mode) ? START : IDLE;
            default:   w_state_nxt = IDLE;
        endcase
    end

    // State, per-state cycle counter, bound latching, address counter and FFT-side outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_done_q    <= 1'b0;
            r_done_qq   <= 1'b0;
            r_lo        <= '0;
            r_hi        <= '0;
            r_thr       <= '0;
            r_addr      <= '0;
            r_fft_start <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= (w_state_nxt != r_state) ? '0 : r_cnt + CNT_W'(1);
            r_done_q    <= fft_done;
            r_done_qq   <= r_done_q;
            r_fft_start <= (w_state_nxt == START);
            r_busy      <= (w_state_nxt != IDLE);
            if (w_start_entry) begin
                r_lo  <= bin_lo;
                r_hi  <= (bin_lo > bin_hi) ? bin_lo : bin_hi;
                r_thr <= threshold;
            end
            // Address only increments while below the latched hi, so it never wraps.
            if ((r_state == WAIT_DONE) && (w_state_nxt == SCAN)) begin
                r_addr <= r_lo;
            end else if ((r_state == SCAN) && (r_addr != r_hi)) begin
                r_addr <= r_addr + ADDR_W'(1);
            end
        end
    end

    // Result capture at REPORT and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_result_valid <= 1'b0;
            r_peak_bin     <= '0;
            r_peak_power   <= '0;
            r_peak_exp     <= '0;
            r_band_sum     <= '0;
            r_above        <= 1'b0;
            r_tmo_err      <= 1'b0;
        end else begin
            r_result_valid <= (r_state == REPORT);
            if (r_state == REPORT) begin
                r_peak_bin   <= w_acc_bin;
                r_peak_power <= w_acc_power;
                r_peak_exp   <= fft_exp;
                r_band_sum   <= w_acc_sum;
                r_above      <= (w_acc_power >= r_thr);
                r_tmo_err    <= 1'b0;
            end else if ((r_state == WAIT_DONE) && (w_state_nxt == IDLE)) begin
                r_tmo_err    <= 1'b1;
            end
        end
    end

    fft_peak_acc #(
        .ADDR_W (ADDR_W),
        .PWR_W  (PWR_W),
        .RD_LAT (RD_LAT),
        .SUM_W  (SUM_W)
    ) u_acc (
        .clk          (clk),
        .reset        (reset),
        .i_clear      (w_start_entry),
        .i_vld        (r_state == SCAN),
        .i_addr       (r_addr),
        .i_power      (fft_power),
        .o_peak_bin   (w_acc_bin),
        .o_peak_power (w_acc_power),
        .o_band_sum   (w_acc_sum)
    );

    assign fft_start    = r_fft_start;
    assign fft_addr     = r_addr;
    assign busy         = r_busy;
    assign result_valid = r_result_valid;
    assign peak_bin     = r_peak_bin;
    assign peak_power   = r_peak_power;
    assign peak_exp     = r_peak_exp;
    assign band_sum     = r_band_sum;
    assign above_thresh = r_above;
    assign timeout_err  = r_tmo_err;

endmodule

// File: tb/tb_fft_scan_ctrl.sv
// Directed bench for fft_scan_ctrl with a latency-2 FFT power memory model.
module tb_fft_scan_ctrl;

    localparam int unsigned AW  = 10;
    localparam int unsigned PW  = 16;
    localparam int unsigned RL  = 2;
    localparam int unsigned SC  = 4;
    localparam int unsigned TMO = 64;
    localparam int unsigned SW  = AW + PW;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic          auto_mode;
    logic          trig;
    logic [AW-1:0] bin_lo;
    logic [AW-1:0] bin_hi;
    logic [PW-1:0] threshold;
    logic          fft_start;
    logic          fft_done;
    logic [AW-1:0] fft_addr;
    logic [PW-1:0] fft_power;
    logic [5:0]    fft_exp;
    logic          busy;
    logic          result_valid;
    logic [AW-1:0] peak_bin;
    logic [PW-1:0] peak_power;
    logic [5:0]    peak_exp;
    logic [SW-1:0] band_sum;
    logic          above_thresh;
    logic          timeout_err;

    always #5 clk = ~clk;

    fft_scan_ctrl #(
        .ADDR_W(AW), .PWR_W(PW), .RD_LAT(RL), .START_CYC(SC), .TMO_CYC(TMO)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .auto_mode(auto_mode), .trig(trig),
        .bin_lo(bin_lo), .bin_hi(bin_hi), .threshold(threshold),
        .fft_start(fft_start), .fft_done(fft_done), .fft_addr(fft_addr),
        .fft_power(fft_power), .fft_exp(fft_exp),
        .busy(busy), .result_valid(result_valid), .peak_bin(peak_bin),
        .peak_power(peak_power), .peak_exp(peak_exp), .band_sum(band_sum),
        .above_thresh(above_thresh), .timeout_err(timeout_err)
    );

    // FFT power memory: data for the address presented in cycle t appears in cycle t+2.
    logic [PW-1:0] mem [1024];
    logic [PW-1:0] r_p1;
    always @(posedge clk) begin
        r_p1      <= mem[fft_addr];
        fft_power <= r_p1;
    end

    typedef struct {
        int lo; int hi; int thr;
        int p0; int p1; int p2; int p3;
        int eb; int ep; int es; int ea;
    } vec_t;

    vec_t tbl [5];
    int   n_chk = 0;
    int   n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_fft_start"}, 32'(fft_start), 0);
        chk({tag, "_fft_addr"}, 32'(fft_addr), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_result_valid"}, 32'(result_valid), 0);
        chk({tag, "_peak_bin"}, 32'(peak_bin), 0);
        chk({tag, "_peak_power"}, 32'(peak_power), 0);
        chk({tag, "_peak_exp"}, 32'(peak_exp), 0);
        chk({tag, "_band_sum"}, 32'(band_sum), 0);
        chk({tag, "_above_thresh"}, 32'(above_thresh), 0);
        chk({tag, "_timeout_err"}, 32'(timeout_err), 0);
    endtask

    // One-shot sweep: trig, fft_done rises 20 cycles after START, wait for the result.
    task automatic do_sweep(input int lo, input int hi, input int thr, input int ex,
                            output int ns, output int nrv, output int tmo);
        int k;
        ns = 0; nrv = 0; tmo = 0; k = 0;
        bin_lo = AW'(lo); bin_hi = AW'(hi); threshold = PW'(thr); fft_exp = 6'(ex);
        fft_done = 1'b0; enable = 1'b1; auto_mode = 1'b0;
        trig = 1'b1; tick(); trig = 1'b0;
        if (fft_start) ns++;
        repeat (19) begin tick(); if (fft_start) ns++; end
        fft_done = 1'b1;
        while (nrv == 0 && k < 200) begin
            tick(); k++;
            if (fft_start) ns++;
            if (result_valid) nrv++;
        end
        if (nrv == 0) tmo = 1;
        repeat (3) begin tick(); if (fft_start) ns++; if (result_valid) nrv++; end
        fft_done = 1'b0;
    endtask

    initial begin
        int ns, nrv, tmo, k, cd, rises, a0;
        logic prev_s, dropped, rv1_start, rv2_busy;

        tbl[0] = '{10,   13,    8,     5,     9,  9,     3,  11,     9,     26, 1};
        tbl[1] = '{0,     3,  100,     1,     2,  3,     4,   3,     4,     10, 0};
        tbl[2] = '{1020, 1023,  7,     7,     7,  7,     7, 1020,   7,     28, 1};
        tbl[3] = '{500,  500,   0,     0,   999, 999,  999, 500,     0,      0, 1};
        tbl[4] = '{20,    22, 65535, 65535, 65535, 1, 50000, 20, 65535, 131071, 1};

        for (int i = 0; i < 1024; i++) mem[i] = '0;
        reset = 1'b1; enable = 1'b0; auto_mode = 1'b0; trig = 1'b0;
        bin_lo = '0; bin_hi = '0; threshold = '0; fft_done = 1'b0; fft_exp = '0;
        repeat (3) tick();
        chk_zero("reset");
        reset = 1'b0;
        tick();

        // Timeout with fft_done held low.
        enable = 1'b1; bin_lo = AW'(1); bin_hi = AW'(2); threshold = '0;
        trig = 1'b1; tick(); trig = 1'b0;
        k = 1; nrv = 0;
        while (!timeout_err && k < 200) begin
            tick(); k++;
            if (result_valid) nrv++;
        end
        chk("tmo_cycle", 32'(k), 32'(1 + SC + TMO));
        chk("tmo_busy", 32'(busy), 0);
        chk("tmo_no_rv", 32'(nrv), 0);
        repeat (5) tick();
        chk("tmo_sticky", 32'(timeout_err), 1);

        // Table of one-shot sweeps.
        for (int i = 0; i < 5; i++) begin
            mem[tbl[i].lo]     = PW'(tbl[i].p0);
            mem[tbl[i].lo + 1] = PW'(tbl[i].p1);
            mem[tbl[i].lo + 2] = PW'(tbl[i].p2);
            mem[tbl[i].lo + 3] = PW'(tbl[i].p3);
            do_sweep(tbl[i].lo, tbl[i].hi, tbl[i].thr, i + 10, ns, nrv, tmo);
            chk($sformatf("row%0d_rv_wait", i), 32'(tmo), 0);
            chk($sformatf("row%0d_start_cycles", i), 32'(ns), SC);
            chk($sformatf("row%0d_rv_pulses", i), 32'(nrv), 1);
            chk($sformatf("row%0d_peak_bin", i), 32'(peak_bin), 32'(tbl[i].eb));
            chk($sformatf("row%0d_peak_power", i), 32'(peak_power), 32'(tbl[i].ep));
            chk($sformatf("row%0d_band_sum", i), 32'(band_sum), 32'(tbl[i].es));
            chk($sformatf("row%0d_above", i), 32'(above_thresh), 32'(tbl[i].ea));
            chk($sformatf("row%0d_peak_exp", i), 32'(peak_exp), 32'(i + 10));
            chk($sformatf("row%0d_timeout_err", i), 32'(timeout_err), 0);
            chk($sformatf("row%0d_busy", i), 32'(busy), 0);
            chk($sformatf("row%0d_addr_hold", i), 32'(fft_addr), 32'(tbl[i].hi));
        end

        // Stale high fft_done and swapped bounds.
        for (int b = 3; b < 7; b++) mem[b] = PW'(11);
        mem[7] = PW'(1234);
        fft_done = 1'b1;
        repeat (3) tick();
        a0 = int'(fft_addr);
        bin_lo = AW'(7); bin_hi = AW'(3); threshold = PW'(2000);
        trig = 1'b1; tick(); trig = 1'b0;
        nrv = 0;
        repeat (39) begin tick(); if (result_valid) nrv++; end
        chk("stale_no_rv", 32'(nrv), 0);
        chk("stale_busy", 32'(busy), 1);
        chk("stale_addr", 32'(fft_addr), 32'(a0));
        fft_done = 1'b0;
        repeat (3) tick();
        fft_done = 1'b1;
        k = 0;
        while (nrv == 0 && k < 60) begin tick(); k++; if (result_valid) nrv++; end
        chk("swap_rv", 32'(nrv), 1);
        chk("swap_peak_bin", 32'(peak_bin), 7);
        chk("swap_peak_power", 32'(peak_power), 1234);
        chk("swap_band_sum", 32'(band_sum), 1234);
        chk("swap_above", 32'(above_thresh), 0);
        fft_done = 1'b0;
        repeat (3) tick();

        // Auto-mode re-arm, enable dropped during the second SCAN.
        mem[40] = PW'(2); mem[41] = PW'(8); mem[42] = PW'(4); mem[43] = PW'(8);
        bin_lo = AW'(40); bin_hi = AW'(43); threshold = PW'(8);
        fft_done = 1'b0; enable = 1'b1; auto_mode = 1'b1;
        k = 0; cd = 0; rises = 0; nrv = 0;
        prev_s = 1'b0; dropped = 1'b0; rv1_start = 1'b0; rv2_busy = 1'b1;
        while (k < 600 && !(dropped && !busy)) begin
            tick(); k++;
            if (fft_start && !prev_s) rises++;
            prev_s = fft_start;
            if (result_valid) begin
                nrv++;
                if (nrv == 1) rv1_start = fft_start;
                if (nrv == 2) rv2_busy = busy;
            end
            if (fft_start) begin
                fft_done = 1'b0; cd = 10;
            end else if (cd > 0) begin
                cd--;
                if (cd == 0) fft_done = 1'b1;
            end
            if (!dropped && rises == 2 && fft_addr == AW'(41)) begin
                enable = 1'b0; dropped = 1'b1;
            end
        end
        chk("auto_done", 32'(k < 600), 1);
        chk("auto_sweeps", 32'(rises), 2);
        chk("auto_rv", 32'(nrv), 2);
        chk("auto_back_to_back", 32'(rv1_start), 1);
        chk("auto_idle_at_rv2", 32'(rv2_busy), 0);
        chk("auto_peak_bin", 32'(peak_bin), 41);
        chk("auto_peak_power", 32'(peak_power), 8);
        chk("auto_band_sum", 32'(band_sum), 22);
        chk("auto_above", 32'(above_thresh), 1);
        ns = 0;
        repeat (10) begin tick(); if (fft_start || busy) ns++; end
        chk("auto_stays_idle", 32'(ns), 0);
        auto_mode = 1'b0; fft_done = 1'b0;

        // Trigger pulsed while busy is ignored.
        bin_lo = AW'(10); bin_hi = AW'(13); threshold = PW'(8); fft_exp = 6'd33;
        enable = 1'b1;
        trig = 1'b1; tick(); trig = 1'b0;
        repeat (8) tick();
        trig = 1'b1; tick(); trig = 1'b0;
        fft_done = 1'b1;
        k = 0; nrv = 0;
        while (nrv == 0 && k < 60) begin tick(); k++; if (result_valid) nrv++; end
        chk("busy_trig_rv", 32'(nrv), 1);
        fft_done = 1'b0;
        ns = 0;
        repeat (40) begin tick(); if (fft_start || busy) ns++; end
        chk("busy_trig_ignored", 32'(ns), 0);
        chk("busy_trig_peak_bin", 32'(peak_bin), 11);

        // Reset in SCAN at address 12.
        trig = 1'b1; tick(); trig = 1'b0;
        repeat (20) tick();
        fft_done = 1'b1;
        k = 0;
        while (!(busy && fft_addr == AW'(12)) && k < 60) begin tick(); k++; end
        chk("scan_reached_12", 32'(k < 60), 1);
        reset = 1'b1;
        tick();
        chk_zero("midreset");
        reset = 1'b0; fft_done = 1'b0;
        nrv = 0; ns = 0;
        repeat (20) begin tick(); if (result_valid) nrv++; if (busy) ns++; end
        chk("midreset_no_rv", 32'(nrv), 0);
        chk("midreset_idle", 32'(ns), 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
